// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SDRAM controller port between I-cache refill,
// D-cache refill and D-cache victim write-back. Issues one line-aligned burst
// per grant, counts beats, steers read data and pulses a per-owner done.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  localparam int unsigned BW       = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  input  logic              d_wb_req,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [DATA_W-1:0] d_wb_data,
  output logic              d_wb_pop,
  output logic [DATA_W-1:0] fill_data,
  output logic [BW-1:0]     fill_index,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              i_done,
  output logic              d_rd_done,
  output logic              d_wb_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [1:0] {StIdle, StCmd, StXfer, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnDrd, OwnDwb} owner_e;

  localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(BURST_LEN - 1);
  localparam logic [BW-1:0]     LastBeat = BW'(BURST_LEN - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              fair_q, fair_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  owner_e            grant;
  logic [ADDR_W-1:0] grant_addr;
  logic              beat;

  // State and datapath registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      lock_q  <= 1'b0;
      fair_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      fair_q  <= fair_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Fixed-order arbitration; lock keeps a write-back and its refill adjacent,
  // fair stops data traffic from starving the I-cache.
  always_comb begin
    grant      = OwnNone;
    grant_addr = '0;
    if (lock_q && d_rd_req) begin
      grant      = OwnDrd;
      grant_addr = d_rd_addr;
    end else if (fair_q && i_req) begin
      grant      = OwnI;
      grant_addr = i_addr;
    end else if (d_wb_req) begin
      grant      = OwnDwb;
      grant_addr = d_wb_addr;
    end else if (d_rd_req) begin
      grant      = OwnDrd;
      grant_addr = d_rd_addr;
    end else if (i_req) begin
      grant      = OwnI;
      grant_addr = i_addr;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    fair_d  = fair_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    beat    = (owner_q == OwnDwb) ? mem_wready : mem_rvalid;
    unique case (state_q)
      StIdle: begin
        if (grant != OwnNone) begin
          owner_d = grant;
          addr_d  = grant_addr & LineMask;
          cnt_d   = '0;
          fair_d  = (grant != OwnI);
          if (grant == OwnDrd) lock_d = 1'b0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (mem_ack) state_d = StXfer;
      end
      StXfer: begin
        if (beat) begin
          cnt_d = cnt_q + BW'(1);
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StDone: begin
        if (owner_q == OwnDwb) lock_d = 1'b1;
        owner_d = OwnNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state with zero-latency beat steering.
  always_comb begin
    busy         = (state_q != StIdle);
    mem_req      = (state_q == StCmd);
    mem_we       = (owner_q == OwnDwb);
    mem_addr     = addr_q;
    mem_wdata    = d_wb_data;
    fill_data    = mem_rdata;
    fill_index   = cnt_q;
    i_fill_valid = (state_q == StXfer) && (owner_q == OwnI) && mem_rvalid;
    d_fill_valid = (state_q == StXfer) && (owner_q == OwnDrd) && mem_rvalid;
    d_wb_pop     = (state_q == StXfer) && (owner_q == OwnDwb) && mem_wready;
    i_done       = (state_q == StDone) && (owner_q == OwnI);
    d_rd_done    = (state_q == StDone) && (owner_q == OwnDrd);
    d_wb_done    = (state_q == StDone) && (owner_q == OwnDwb);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (ADDR_W=24, DATA_W=16, BURST_LEN=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_rd_req, d_wb_req;
  logic [23:0] i_addr, d_rd_addr, d_wb_addr;
  logic [15:0] d_wb_data, mem_rdata;
  logic        d_wb_pop, i_fill_valid, d_fill_valid, i_done, d_rd_done, d_wb_done;
  logic [15:0] fill_data, mem_wdata;
  logic [2:0]  fill_index;
  logic        busy, mem_req, mem_we, mem_ack, mem_rvalid, mem_wready;
  logic [23:0] mem_addr;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr),
    .d_wb_req(d_wb_req), .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .d_wb_pop(d_wb_pop), .fill_data(fill_data), .fill_index(fill_index),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_done(i_done), .d_rd_done(d_rd_done), .d_wb_done(d_wb_done),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wready(mem_wready), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 0; d_rd_req = 0; d_wb_req = 0;
    i_addr = '0; d_rd_addr = '0; d_wb_addr = '0; d_wb_data = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0; mem_wready = 0;
    tick(); tick();
    #1;
    n_vec++;
    if ({busy, mem_req, mem_we, i_fill_valid, d_fill_valid, d_wb_pop, i_done, d_rd_done,
         d_wb_done} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 000000000", {busy, mem_req, mem_we, i_fill_valid,
               d_fill_valid, d_wb_pop, i_done, d_rd_done, d_wb_done});
    end
    n_vec++;
    if (mem_addr !== 24'h0 || fill_index !== 3'd0) begin
      n_err++;
      $display("FAIL reset_regs: got addr %h idx %0d want 000000 0", mem_addr, fill_index);
    end
    rst = 1'b0;
    tick();
  endtask

  // Entered in CMD after a read grant; leaves the DUT in DONE with the done checked.
  task automatic run_read(input bit own_i, input logic [15:0] seed);
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cmd: got req %b we %b want 1 0", mem_req, mem_we);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rd_req_drop: got req %b busy %b want 0 1", mem_req, busy);
    end
    for (int b = 0; b < 8; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = seed + 16'(b);
      #1;
      n_vec++;
      if (i_fill_valid !== own_i || d_fill_valid !== !own_i || fill_index !== 3'(b) ||
          fill_data !== seed + 16'(b)) begin
        n_err++;
        $display("FAIL rd_beat%0d: got iv %b dv %b idx %0d data %h want %b %b %0d %h", b,
                 i_fill_valid, d_fill_valid, fill_index, fill_data, own_i, !own_i, b,
                 seed + 16'(b));
      end
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    n_vec++;
    if (i_done !== own_i || d_rd_done !== !own_i || d_wb_done !== 1'b0) begin
      n_err++;
      $display("FAIL rd_done: got %b%b%b want %b%b0", i_done, d_rd_done, d_wb_done, own_i,
               !own_i);
    end
  endtask

  task automatic test_lone_read();
    i_req  = 1'b1;
    i_addr = 24'h001234;
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h001230 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL lone_addr: got %h busy %b want 001230 1", mem_addr, busy);
    end
    run_read(1'b1, 16'hA000);
    i_req = 1'b0;
    tick();
    #1;
    n_vec++;
    if (i_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL lone_idle: got done %b busy %b want 0 0", i_done, busy);
    end
  endtask

  task automatic test_wb_then_rd();
    d_wb_req = 1'b1; d_wb_addr = 24'h00ABCF;
    d_rd_req = 1'b1; d_rd_addr = 24'h000455;
    i_req    = 1'b1; i_addr    = 24'h00200B;
    tick();
    #1;
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h00ABC8) begin
      n_err++;
      $display("FAIL wb_grant: got req %b we %b addr %h want 1 1 00abc8", mem_req, mem_we,
               mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mem_wready = 1'b1;
      d_wb_data  = 16'h5000 + 16'(b);
      #1;
      n_vec++;
      if (d_wb_pop !== 1'b1 || fill_index !== 3'(b) || mem_wdata !== 16'h5000 + 16'(b)) begin
        n_err++;
        $display("FAIL wb_beat%0d: got pop %b idx %0d wdata %h want 1 %0d %h", b, d_wb_pop,
                 fill_index, mem_wdata, b, 16'h5000 + 16'(b));
      end
      tick();
      if (b[0] && b < 7) begin
        mem_wready = 1'b0;
        #1;
        n_vec++;
        if (d_wb_pop !== 1'b0 || fill_index !== 3'(b + 1)) begin
          n_err++;
          $display("FAIL wb_gap%0d: got pop %b idx %0d want 0 %0d", b, d_wb_pop, fill_index,
                   b + 1);
        end
        tick();
      end
    end
    mem_wready = 1'b0;
    #1;
    n_vec++;
    if (d_wb_done !== 1'b1 || d_rd_done !== 1'b0 || i_done !== 1'b0) begin
      n_err++;
      $display("FAIL wb_done: got %b%b%b want 100", d_wb_done, d_rd_done, i_done);
    end
    d_wb_req = 1'b0;
    tick();
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h000450 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL lock_grant: got addr %h we %b want 000450 0", mem_addr, mem_we);
    end
    run_read(1'b0, 16'hD000);
    d_rd_req = 1'b0;
    tick();
  endtask

  // i_req held throughout; each data grant must be followed by an I grant.
  task automatic test_fair();
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h002008) begin
      n_err++;
      $display("FAIL fair_i1: got addr %h want 002008", mem_addr);
    end
    d_rd_req  = 1'b1;
    d_rd_addr = 24'h000467;
    run_read(1'b1, 16'h1100);
    tick();
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h000460) begin
      n_err++;
      $display("FAIL fair_drd: got addr %h want 000460", mem_addr);
    end
    run_read(1'b0, 16'h2200);
    tick();
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h002008) begin
      n_err++;
      $display("FAIL fair_i2: got addr %h want 002008 (d_rd_req still high)", mem_addr);
    end
    d_rd_req = 1'b0;
    run_read(1'b1, 16'h3300);
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_delayed_ack();
    i_req  = 1'b1;
    i_addr = 24'h00FFFF;
    tick();
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = c[0];
      #1;
      n_vec++;
      if (mem_req !== 1'b1 || i_fill_valid !== 1'b0 || fill_index !== 3'd0 ||
          mem_addr !== 24'h00FFF8) begin
        n_err++;
        $display("FAIL ack_wait%0d: got req %b iv %b idx %0d addr %h want 1 0 0 00fff8", c,
                 mem_req, i_fill_valid, fill_index, mem_addr);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == 2 || b == 5) begin
        mem_rvalid = 1'b0;
        #1;
        n_vec++;
        if (i_fill_valid !== 1'b0 || fill_index !== 3'(b)) begin
          n_err++;
          $display("FAIL stall%0d: got iv %b idx %0d want 0 %0d", b, i_fill_valid, fill_index, b);
        end
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hBEE0 + 16'(b);
      #1;
      n_vec++;
      if (i_fill_valid !== 1'b1 || fill_index !== 3'(b) || fill_data !== 16'hBEE0 + 16'(b)) begin
        n_err++;
        $display("FAIL slow_beat%0d: got iv %b idx %0d want 1 %0d", b, i_fill_valid,
                 fill_index, b);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    n_vec++;
    if (i_done !== 1'b1) begin
      n_err++;
      $display("FAIL slow_done: got %b want 1", i_done);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    i_req  = 1'b1;
    i_addr = 24'h000105;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      tick();
    end
    rst   = 1'b1;
    i_req = 1'b0;
    #1;
    n_vec++;
    if ({busy, mem_req, i_fill_valid, i_done} !== 4'b0 || fill_index !== 3'd0 ||
        mem_addr !== 24'h0) begin
      n_err++;
      $display("FAIL rst_mid: got ctl %b idx %0d addr %h want 0000 0 000000",
               {busy, mem_req, i_fill_valid, i_done}, fill_index, mem_addr);
    end
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    #1;
    n_vec++;
    if (i_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_nodone: got done %b busy %b want 0 0", i_done, busy);
    end
    i_req  = 1'b1;
    i_addr = 24'h000200;
    tick();
    #1;
    n_vec++;
    if (mem_addr !== 24'h000200 || fill_index !== 3'd0) begin
      n_err++;
      $display("FAIL rst_fresh: got addr %h idx %0d want 000200 0", mem_addr, fill_index);
    end
    run_read(1'b1, 16'h7700);
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_read();
    test_wb_then_rd();
    test_fair();
    test_delayed_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
